univ_shift_register: RTL and testbench

UNIV_SHIFT_REGISTER -- requirements
Module: univ_shift_register

---
 rtl/univ_shift_register.sv | 154 +++++++++++++++
 tb/tb_univ_shift_register.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_register.sv
// Universal shift register: parallel load/clear, or N single-bit shifts/rotates via an IDLE/SHIFT/DONE FSM.
// Latency: LOAD/CLR/NOP/zero-amount finish on the start edge; shifts take one edge each, then done pulses for one cycle.
// No backpressure: start is sampled only in IDLE; abort cancels a running shift without a done pulse.
module univ_shift_register #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] load_data,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    output logic [WIDTH-1:0] q,
    output logic             last_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_LOAD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ASR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_NOP  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               last_q, last_d;
    logic [2:0]         mode_q, mode_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   shifted;
    logic               shift_out;

    // One step of the latched operation; fill bits come straight from the pins each edge.
    always_comb begin
        shifted   = q_q;
        shift_out = 1'b0;
        case (mode_q)
            MODE_SHL: begin
                shifted   = {q_q[WIDTH-2:0], sin_lsb};
                shift_out = q_q[WIDTH-1];
            end
            MODE_SHR: begin
                shifted   = {sin_msb, q_q[WIDTH-1:1]};
                shift_out = q_q[0];
            end
            MODE_ASR: begin
                shifted   = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                shift_out = q_q[0];
            end
            MODE_ROL: begin
                shifted   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                shift_out = q_q[WIDTH-1];
            end
            default: begin
                shifted   = {q_q[0], q_q[WIDTH-1:1]};
                shift_out = q_q[0];
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        last_d  = last_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    case (mode)
                        MODE_LOAD: begin
                            q_d     = load_data;
                            last_d  = 1'b0;
                            state_d = ST_DONE;
                        end
                        MODE_CLR: begin
                            q_d     = '0;
                            last_d  = 1'b0;
                            state_d = ST_DONE;
                        end
                        MODE_NOP: state_d = ST_DONE;
                        default: begin
                            if (amount == '0) begin
                                state_d = ST_DONE;
                            end else begin
                                mode_d  = mode;
                                cnt_d   = amount;
                                state_d = ST_SHIFT;
                            end
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    q_d    = shifted;
                    last_d = shift_out;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == AMT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            last_q  <= 1'b0;
            mode_q  <= MODE_SHL;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q        = q_q;
    assign last_out = last_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_univ_shift_register.sv
// Scoreboarded bench for univ_shift_register: directed vectors plus randomized operations against an arithmetic model.
module tb_univ_shift_register;

    localparam int W = 8;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [2:0]   mode = 3'd0;
    logic [A-1:0] amount = '0;
    logic [W-1:0] load_data = '0;
    logic         sin_lsb = 1'b0;
    logic         sin_msb = 1'b0;
    logic [W-1:0] q;
    logic         last_out;
    logic         busy;
    logic         done;

    univ_shift_register #(.WIDTH(W), .AMT_W(A)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .amount(amount), .load_data(load_data), .sin_lsb(sin_lsb), .sin_msb(sin_msb),
        .q(q), .last_out(last_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic         last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mq = 0;
    int   mlast = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one shift step expressed with integer arithmetic.
    task automatic model_shift(input int m, input int sl, input int sm);
        case (m)
            1: begin mlast = mq / 128; mq = (mq * 2) % 256 + sl; end
            2: begin mlast = mq % 2;   mq = mq / 2 + sm * 128; end
            3: begin mlast = mq % 2;   mq = mq / 2 + (mq / 128) * 128; end
            4: begin mlast = mq / 128; mq = (mq * 2) % 256 + mlast; end
            default: begin mlast = mq % 2; mq = mq / 2 + mlast * 128; end
        endcase
    endtask

    task automatic push_exp();
        exp_t e;
        e.q    = W'(mq);
        e.last = 1'(mlast);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_q", 32'(q), 32'(e.q));
                chk("sb_last", 32'(last_out), 32'(e.last));
            end
        end
    end

    // kill_kind: 0 none, 1 abort before shift edge kill_at, 2 async reset during shift kill_at.
    task automatic run_op(input int m, input int amt, input int data, input int kill_kind,
                          input int kill_at, input int fix_sin, input int sl_f, input int sm_f);
        int busy_cnt = 0;
        bit killed = 0;
        bit will_shift = (m >= 1 && m <= 5 && amt > 0);
        start = 1'b1; abort = 1'b0; mode = 3'(m); amount = A'(amt); load_data = W'(data);
        if (!will_shift) begin
            if (m == 0) begin mq = data; mlast = 0; end
            if (m == 6) begin mq = 0; mlast = 0; end
            push_exp();
        end
        @(posedge clk); #1;
        if (will_shift) begin
            for (int k = 0; k < amt && !killed; k++) begin
                int sl = fix_sin ? sl_f : int'($urandom_range(0, 1));
                int sm = fix_sin ? sm_f : int'($urandom_range(0, 1));
                sin_lsb = 1'(sl); sin_msb = 1'(sm);
                start = 1'($urandom_range(0, 1));
                mode = 3'($urandom_range(0, 7));
                amount = A'($urandom_range(0, 15));
                load_data = W'($urandom_range(0, 255));
                abort = (kill_kind == 1 && k == kill_at);
                @(negedge clk);
                if (busy === 1'b1) busy_cnt++;
                if (kill_kind == 2 && k == kill_at) begin
                    reset = 1'b0; start = 1'b0;
                    #1;
                    chk("rst_q", 32'(q), 32'h0);
                    chk("rst_busy", 32'(busy), 32'h0);
                    chk("rst_done", 32'(done), 32'h0);
                    chk("rst_last", 32'(last_out), 32'h0);
                    #1 reset = 1'b1;
                    mq = 0; mlast = 0; killed = 1;
                end
                @(posedge clk); #1;
                if (abort) begin
                    killed = 1;
                end else if (!killed) begin
                    model_shift(m, sl, sm);
                    chk("step_q", 32'(q), 32'(mq));
                    chk("step_last", 32'(last_out), 32'(mlast));
                end
            end
            if (!killed) push_exp();
            chk("busy_cycles", 32'(busy_cnt), killed ? 32'(kill_at + 1) : 32'(amt));
        end
        start = killed ? 1'b0 : 1'($urandom_range(0, 1));
        abort = killed ? 1'b0 : 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("post_busy", 32'(busy), 32'h0);
        chk("post_q", 32'(q), 32'(mq));
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("reset_q", 32'(q), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_last", 32'(last_out), 32'h0);
        #4 reset = 1'b1;
        @(posedge clk); #1;

        run_op(0, 0, 'h55, 0, 0, 0, 0, 0);
        run_op(1, 5, 0, 2, 2, 0, 0, 0);
        run_op(0, 0, 'hB6, 0, 0, 0, 0, 0);
        chk("load_b6", 32'(q), 32'hB6);
        run_op(1, 3, 0, 0, 0, 1, 1, 0);
        chk("shl_b7", 32'(q), 32'hB7);
        chk("shl_last", 32'(last_out), 32'h1);
        run_op(0, 0, 'h96, 0, 0, 0, 0, 0);
        run_op(3, 2, 0, 0, 0, 0, 0, 0);
        chk("asr_e5", 32'(q), 32'hE5);
        chk("asr_last", 32'(last_out), 32'h1);
        run_op(0, 0, 'hA5, 0, 0, 0, 0, 0);
        run_op(5, 8, 0, 0, 0, 0, 0, 0);
        chk("ror8_a5", 32'(q), 32'hA5);
        run_op(0, 0, 'h81, 0, 0, 0, 0, 0);
        run_op(4, 5, 0, 1, 2, 0, 0, 0);
        chk("rol_abort_06", 32'(q), 32'h06);
        run_op(0, 0, 'h3C, 0, 0, 0, 0, 0);
        run_op(2, 0, 0, 0, 0, 0, 0, 0);
        chk("shr0_3c", 32'(q), 32'h3C);

        start = 1'b1; abort = 1'b1; mode = 3'd0; load_data = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_q", 32'(q), 32'h3C);
        chk("idle_abort_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;

        run_op(1, 15, 0, 0, 0, 0, 0, 0);
        run_op(6, 0, 0, 0, 0, 0, 0, 0);
        run_op(7, 3, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            int m = int'($urandom_range(0, 7));
            int amt = int'($urandom_range(0, 15));
            int kk = ($urandom_range(0, 7) == 0 && amt > 0) ? 1 : 0;
            int ka = (amt > 0) ? int'($urandom_range(0, amt - 1)) : 0;
            run_op(m, amt, int'($urandom_range(0, 255)), kk, ka, 0, 0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
